// File: rtl/as_fifo_pkg.sv
// as_fifo_pkg: shared constants and helpers for the as_fifo block.
//   DATA_WIDTH  default stored word width
//   ADDR_SIZE   default memory address width (pointers are one bit wider)
//   FIFO_DEPTH  default number of entries (2**ADDR_SIZE)
//   NUM_STAGES  default pointer-synchronizer depth
//   bin2gray()  binary to reflected Gray code; callers truncate to pointer width
package as_fifo_pkg;

    localparam int unsigned DATA_WIDTH = 8;
    localparam int unsigned ADDR_SIZE  = 4;
    localparam int unsigned FIFO_DEPTH = 16;
    localparam int unsigned NUM_STAGES = 2;

    function automatic logic [31:0] bin2gray(input logic [31:0] bin);
        return bin ^ (bin >> 1);
    endfunction

endpackage

// File: rtl/as_fifo_sync.sv
// as_fifo_sync: Stages-deep register chain carrying a Gray pointer from one
// side of the FIFO to the other.
//   clk_i  clock
//   rst_i  synchronous active-high reset, clears every stage
//   d_i    pointer from the producing side
//   q_o    pointer delayed by Stages edges
module as_fifo_sync #(
    parameter int unsigned Width  = as_fifo_pkg::ADDR_SIZE + 1,
    parameter int unsigned Stages = as_fifo_pkg::NUM_STAGES
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);

    logic [Width-1:0] stage_q [Stages];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(Stages); i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < int'(Stages); i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q_o = stage_q[Stages-1];

endmodule

// File: rtl/as_fifo_top.sv
// as_fifo_top: single-clock FIFO with Gray pointers exchanged through
// NUM_STAGES-deep synchronizers so flag timing matches the dual-clock part.
//   I_CLK       clock, all state changes on the rising edge
//   I_RST       synchronous active-high reset, clears pointers and memory
//   I_W_INC     write request, ignored while FIFO_Full
//   I_Data      write data
//   I_R_INC     read request (pop), ignored while FIFO_Empty
//   O_Data      head-of-FIFO word (first-word fall-through)
//   FIFO_Full   no further writes accepted
//   FIFO_Empty  no valid data at head
module as_fifo_top #(
    parameter int unsigned Data_Width = as_fifo_pkg::DATA_WIDTH,
    parameter int unsigned Addr_Size  = as_fifo_pkg::ADDR_SIZE,
    parameter int unsigned FIFO_Dipth = as_fifo_pkg::FIFO_DEPTH,
    parameter int unsigned NUM_STAGES = as_fifo_pkg::NUM_STAGES
) (
    input  logic                  I_CLK,
    input  logic                  I_RST,
    input  logic                  I_W_INC,
    input  logic [Data_Width-1:0] I_Data,
    input  logic                  I_R_INC,
    output logic [Data_Width-1:0] O_Data,
    output logic                  FIFO_Full,
    output logic                  FIFO_Empty
);

    import as_fifo_pkg::*;

    localparam int unsigned PtrW = Addr_Size + 1;

    logic [Data_Width-1:0] mem_q [FIFO_Dipth];

    logic [PtrW-1:0] wbin_q, wbin_d, wgray_q, wgray_d;
    logic [PtrW-1:0] rbin_q, rbin_d, rgray_q, rgray_d;
    logic [PtrW-1:0] wgray_s, rgray_s;
    logic            w_en, r_en;

    assign w_en = I_W_INC & ~FIFO_Full;
    assign r_en = I_R_INC & ~FIFO_Empty;

    always_comb begin
        wbin_d  = wbin_q + PtrW'(w_en);
        rbin_d  = rbin_q + PtrW'(r_en);
        wgray_d = PtrW'(bin2gray(32'(wbin_d)));
        rgray_d = PtrW'(bin2gray(32'(rbin_d)));
    end

    always_ff @(posedge I_CLK) begin
        if (I_RST) begin
            wbin_q  <= '0;
            wgray_q <= '0;
            rbin_q  <= '0;
            rgray_q <= '0;
        end else begin
            wbin_q  <= wbin_d;
            wgray_q <= wgray_d;
            rbin_q  <= rbin_d;
            rgray_q <= rgray_d;
        end
    end

    always_ff @(posedge I_CLK) begin
        if (I_RST) begin
            for (int i = 0; i < int'(FIFO_Dipth); i++) begin
                mem_q[i] <= '0;
            end
        end else if (w_en) begin
            mem_q[wbin_q[Addr_Size-1:0]] <= I_Data;
        end
    end

    // Write pointer as seen by the read side.
    as_fifo_sync #(
        .Width  (PtrW),
        .Stages (NUM_STAGES)
    ) u_sync_w2r (
        .clk_i (I_CLK),
        .rst_i (I_RST),
        .d_i   (wgray_q),
        .q_o   (wgray_s)
    );

    // Read pointer as seen by the write side.
    as_fifo_sync #(
        .Width  (PtrW),
        .Stages (NUM_STAGES)
    ) u_sync_r2w (
        .clk_i (I_CLK),
        .rst_i (I_RST),
        .d_i   (rgray_q),
        .q_o   (rgray_s)
    );

    assign O_Data     = mem_q[rbin_q[Addr_Size-1:0]];
    assign FIFO_Empty = (rgray_q == wgray_s);
    // In Gray code a pointer one lap ahead differs in the top two bits only.
    assign FIFO_Full  = (wgray_q == {~rgray_s[Addr_Size:Addr_Size-1],
                                     rgray_s[Addr_Size-2:0]});

endmodule

// File: tb/tb_as_fifo_top.sv
module tb_as_fifo_top;

    logic       I_CLK;
    logic       I_RST;
    logic       I_W_INC;
    logic [7:0] I_Data;
    logic       I_R_INC;
    logic [7:0] O_Data;
    logic       FIFO_Full;
    logic       FIFO_Empty;

    int n_checks;
    int n_fail;

    as_fifo_top #(
        .Data_Width (8),
        .Addr_Size  (4),
        .FIFO_Dipth (16),
        .NUM_STAGES (2)
    ) dut (
        .I_CLK      (I_CLK),
        .I_RST      (I_RST),
        .I_W_INC    (I_W_INC),
        .I_Data     (I_Data),
        .I_R_INC    (I_R_INC),
        .O_Data     (O_Data),
        .FIFO_Full  (FIFO_Full),
        .FIFO_Empty (FIFO_Empty)
    );

    initial I_CLK = 1'b0;
    always #5 I_CLK = ~I_CLK;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Advance one edge; inputs change and outputs are sampled 1 ns after it.
    task automatic tick();
        @(posedge I_CLK);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        I_W_INC = 1'b1;
        I_Data  = d;
        tick();
        I_W_INC = 1'b0;
    endtask

    // Wait (bounded) for data, check the head word, then pop it.
    task automatic pop_check(input string tag, input logic [7:0] exp);
        int n = 0;
        while (FIFO_Empty && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_avail"}, 32'(FIFO_Empty), 32'd0);
        check(tag, 32'(O_Data), 32'(exp));
        I_R_INC = 1'b1;
        tick();
        I_R_INC = 1'b0;
    endtask

    logic [7:0] ordered [9];
    int wi, ri, full_seen;
    logic do_w, do_r;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        ordered  = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF, 8'h55};
        I_RST    = 1'b1;
        I_W_INC  = 1'b0;
        I_R_INC  = 1'b0;
        I_Data   = 8'h00;
        tick();
        tick();
        I_RST = 1'b0;

        // Reset state
        check("rst_empty", 32'(FIFO_Empty), 32'd1);
        check("rst_full", 32'(FIFO_Full), 32'd0);
        check("rst_data", 32'(O_Data), 32'h00);

        // Read while empty is ignored
        I_R_INC = 1'b1;
        tick();
        I_R_INC = 1'b0;
        check("uflow_empty", 32'(FIFO_Empty), 32'd1);

        // Empty latency: write at edge k, flag falls after edge k+2
        push(8'hA5);
        check("lat_k", 32'(FIFO_Empty), 32'd1);
        tick();
        check("lat_k1", 32'(FIFO_Empty), 32'd1);
        tick();
        check("lat_k2", 32'(FIFO_Empty), 32'd0);
        check("lat_data", 32'(O_Data), 32'hA5);
        pop_check("lat_pop", 8'hA5);
        check("lat_empty_after", 32'(FIFO_Empty), 32'd1);

        // Ordered transfer
        for (int i = 0; i < 9; i++) push(ordered[i]);
        check("ord_nofull", 32'(FIFO_Full), 32'd0);
        for (int i = 0; i < 9; i++) pop_check($sformatf("ord_%0d", i), ordered[i]);
        tick();
        tick();
        check("ord_empty", 32'(FIFO_Empty), 32'd1);

        // Full and overflow
        for (int i = 0; i < 16; i++) push(8'(i));
        check("full_16", 32'(FIFO_Full), 32'd1);
        push(8'h10);
        check("full_17", 32'(FIFO_Full), 32'd1);
        pop_check("full_rd_0", 8'h00);
        check("full_hold_0", 32'(FIFO_Full), 32'd1);
        tick();
        check("full_hold_1", 32'(FIFO_Full), 32'd1);
        tick();
        check("full_release", 32'(FIFO_Full), 32'd0);
        for (int i = 1; i < 16; i++) pop_check($sformatf("full_rd_%0d", i), 8'(i));
        tick();
        tick();
        check("full_drained", 32'(FIFO_Empty), 32'd1);

        // Streaming with simultaneous read/write across pointer wrap
        wi = 0;
        ri = 0;
        full_seen = 0;
        for (int c = 0; c < 400 && ri < 40; c++) begin
            do_w = (wi < 40) && !FIFO_Full;
            do_r = !FIFO_Empty;
            if (FIFO_Full) full_seen++;
            I_W_INC = do_w;
            I_Data  = 8'((wi * 3) % 256);
            I_R_INC = do_r;
            if (do_r) check($sformatf("strm_%0d", ri), 32'(O_Data), 32'((ri * 3) % 256));
            tick();
            if (do_w) wi++;
            if (do_r) ri++;
        end
        I_W_INC = 1'b0;
        I_R_INC = 1'b0;
        check("strm_count", 32'(ri), 32'd40);
        check("strm_nofull", 32'(full_seen), 32'd0);

        // Mid-operation reset discards contents
        for (int i = 0; i < 5; i++) push(8'h11 + 8'(i));
        I_RST = 1'b1;
        tick();
        I_RST = 1'b0;
        check("mrst_empty", 32'(FIFO_Empty), 32'd1);
        check("mrst_full", 32'(FIFO_Full), 32'd0);
        check("mrst_data", 32'(O_Data), 32'h00);
        push(8'h77);
        pop_check("mrst_new", 8'h77);
        tick();
        tick();
        check("mrst_empty_end", 32'(FIFO_Empty), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/as_fifo_top.md
Name: as_fifo_top

Overview:
- Single-clock FIFO buffer with a registered-memory array, Gray-coded read/write pointers, and conservative full/empty flags.
- Pointer exchange between the write side and the read side passes through NUM_STAGES register stages. This keeps flag timing identical to the dual-clock variant, so the block is a drop-in for the multi-clock communication path.
- Sits between a byte producer (write side) and a consumer (read side) in the system datapath.

Parameters:
- Data_Width, 8, width of each stored word.
- Addr_Size, 4, memory address width; pointers are Addr_Size+1 bits.
- FIFO_Dipth, 16, number of entries; must equal 2**Addr_Size.
- NUM_STAGES, 2, pointer-synchronizer depth (>=1) between the write-side and read-side views.

Ports:
- I_CLK  in  1  single clock; all state changes on the rising edge.
- I_RST  in  1  reset; synchronous, active-high.
- I_W_INC  in  1  write request.
- I_Data  in  Data_Width  write data, sampled with I_W_INC.
- I_R_INC  in  1  read request (pop).
- O_Data  out  Data_Width  head-of-FIFO word (first-word fall-through).
- FIFO_Full  out  1  no further writes accepted.
- FIFO_Empty  out  1  no valid data at head.

Behaviour:
- Reset (I_RST=1 at posedge):
  - Binary and Gray pointers, and all synchronizer stages, go to 0.
  - Memory is cleared to 0.
  - Resulting outputs: FIFO_Empty=1, FIFO_Full=0, O_Data=0.
  - Reset overrides simultaneous I_W_INC/I_R_INC; reset mid-operation discards all contents.
- Write: at posedge with I_W_INC=1 and FIFO_Full=0:
  - mem[wbin[Addr_Size-1:0]] <= I_Data.
  - wbin increments by 1, wrapping modulo 2**(Addr_Size+1); wgray = wbin ^ (wbin>>1), registered.
  - A write while FIFO_Full=1 is ignored: no memory or pointer change.
- Read: at posedge with I_R_INC=1 and FIFO_Empty=0, rbin/rgray advance the same way.
  - A read while FIFO_Empty=1 is ignored.
- O_Data = mem[rbin[Addr_Size-1:0]], combinational from the registered pointer and memory.
  - The value present before a read edge is the word consumed by that edge.
- Synchronizers:
  - wgray passes through NUM_STAGES flops to give wgray_s (read side).
  - rgray passes through NUM_STAGES flops to give rgray_s (write side).
- FIFO_Empty = (rgray == wgray_s), combinational from registers.
  - After the first write into an empty FIFO at edge k, FIFO_Empty falls after edge k+NUM_STAGES.
- FIFO_Full = (wgray == {~rgray_s[A:A-1], rgray_s[A-2:0]}), with A = Addr_Size.
  - Asserts immediately after the edge performing the 16th outstanding write.
  - Deasserts NUM_STAGES edges after the freeing read.
- Flags are conservative, never optimistic: no overflow and no underflow under any stimulus.
- Simultaneous legal read and write in one cycle are both performed.
- Pointer wrap-around is transparent; the MSB distinguishes full from empty.

Decomposition:
- Package as_fifo_pkg:
  - Default constants DATA_WIDTH=8, ADDR_SIZE=4, FIFO_DEPTH=16, NUM_STAGES=2.
  - Function bin2gray.
- One sub-module, as_fifo_sync: NUM_STAGES-deep, (Addr_Size+1)-bit register chain with synchronous reset.
  - Instantiated twice, once for each pointer direction.
- Memory, pointer logic, and flags live in the top.

Test Plan:
- Reset: hold I_RST=1 for 2 cycles -> FIFO_Empty=1, FIFO_Full=0, O_Data=0x00; I_R_INC=1 while empty leaves pointers unchanged.
- Ordered transfer: write 01,23,45,67,89,AB,CD,EF,55 on consecutive cycles, then read 9 times once FIFO_Empty=0 -> O_Data before each read edge matches that order, 0 mismatches, FIFO_Empty=1 NUM_STAGES cycles after the last write is consumed.
- Empty latency: single write of 0xA5 at edge k -> FIFO_Empty stays 1 through edge k+1 and falls after edge k+2; O_Data=0xA5.
- Full and overflow: 17 writes of 0x00..0x10 with no reads -> FIFO_Full=1 after the 16th write; the 17th write (0x10) is dropped; 16 reads return 0x00..0x0F.
- Wrap/simultaneous: stream 40 words (i*3 mod 256) with I_W_INC=I_R_INC=1 whenever allowed -> all 40 read in order across pointer wrap, with no false Full.
- Mid-operation reset: write 5 words, assert I_RST for 1 cycle -> FIFO_Empty=1, FIFO_Full=0; the next write/read pair returns only the new word.
